uds_seq_ctrl: RTL and testbench

Job sequencer for the UDS upsample/downsample engine. It accepts a job (mode, scale, tile count), then for each tile:
- pulls the tile from an upstream valid/ready stream,
- drives the UDS load/active timing,
- waits for the result,
- presents a result strobe to a downstream sink with backpressure.

It sits between the tile buffer and UDS, and owns all UDS control inputs.

---
 rtl/uds_pkg.sv | 27 ++
 rtl/uds_tile_cnt.sv | 28 ++
 rtl/uds_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_uds_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uds_pkg.sv
// Shared definitions for the UDS job sequencer: FSM states, function/scale
// encodings and default tile geometry.
package uds_pkg;

  localparam int UDS_A  = 64;
  localparam int UDS_DW = 32;

  localparam logic [1:0] FUNC_DOWN_MAX = 2'b00;
  localparam logic [1:0] FUNC_DOWN_AVG = 2'b01;
  localparam logic [1:0] FUNC_UPSAMPLE = 2'b10;
  localparam logic [1:0] SCALE_2X2     = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_HOLD,
    ST_DONE
  } uds_state_e;

  function automatic logic is_upsample(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/uds_tile_cnt.sv
// Up-counter with synchronous load and a terminal-value flag; used for the
// tile index and, when UDS_WDOG_EN is defined, the drain watchdog.
module uds_tile_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == last_val);

endmodule

// File: rtl/uds_seq_ctrl.sv
// Job sequencer for the UDS engine: fetches tiles, drives UDS load/active,
// waits for results and hands them to a backpressured sink.
// Optional drain watchdog enabled by defining UDS_WDOG_EN.
module uds_seq_ctrl
  import uds_pkg::*;
#(
  parameter int A     = UDS_A,
  parameter int DW    = UDS_DW,
  parameter int CNT_W = 8
`ifdef UDS_WDOG_EN
  ,
  parameter int WDOG_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [1:0]        cfg_mode,
  input  logic [1:0]        cfg_scale,
  input  logic [CNT_W-1:0]  cfg_tiles,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A*DW-1:0]   in_data,
  output logic [A*DW-1:0]   uds_idata,
  output logic              uds_idata_valid,
  output logic              uds_active,
  output logic [1:0]        uds_function_mode,
  output logic [1:0]        uds_scale_factor,
  input  logic              uds_odata_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_tile_idx
);

  uds_state_e       state, nxt;
  logic [CNT_W-1:0] tiles_q;
  logic             err_q;
  logic             start_acc, start_bad, start_empty;
  logic             idx_load, idx_inc, idx_last;
  logic             wdog_expire;

  assign start_acc   = (state == ST_IDLE) && cfg_start;
  assign start_empty = (cfg_tiles == '0);
  assign start_bad   = !is_upsample(cfg_mode) && (cfg_scale != SCALE_2X2);

  uds_tile_cnt #(.W(CNT_W)) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (idx_load),
    .load_val ('0),
    .inc      (idx_inc),
    .last_val (tiles_q - 1'b1),
    .cnt      (out_tile_idx),
    .last     (idx_last)
  );

`ifdef UDS_WDOG_EN
  localparam int WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_last;

  // Cleared while in COMPUTE so the count starts at zero on the first DRAIN cycle.
  uds_tile_cnt #(.W(WDOG_W)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_COMPUTE),
    .load_val ('0),
    .inc      (state == ST_DRAIN),
    .last_val (WDOG_W'(WDOG_CYC - 1)),
    .cnt      (wdog_cnt),
    .last     (wdog_last)
  );
  assign wdog_expire = (state == ST_DRAIN) && !uds_odata_valid && wdog_last;
`else
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt      = state;
    idx_load = 1'b0;
    idx_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          idx_load = 1'b1;
          if (start_empty || start_bad) nxt = ST_DONE;
          else                          nxt = ST_FETCH;
        end
      end
      ST_FETCH:   if (in_valid) nxt = ST_LOAD;
      ST_LOAD:    nxt = ST_COMPUTE;
      ST_COMPUTE: nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (uds_odata_valid)  nxt = ST_HOLD;
        else if (wdog_expire) nxt = ST_DONE;
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (idx_last) begin
            nxt = ST_DONE;
          end else begin
            idx_inc = 1'b1;
            nxt     = ST_FETCH;
          end
        end
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Job configuration and sticky error; an empty job never flags an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uds_function_mode <= '0;
      uds_scale_factor  <= '0;
      tiles_q           <= '0;
      err_q             <= 1'b0;
    end else begin
      if (start_acc) begin
        uds_function_mode <= cfg_mode;
        uds_scale_factor  <= cfg_scale;
        tiles_q           <= cfg_tiles;
        err_q             <= !start_empty && start_bad;
      end else if (wdog_expire) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uds_idata <= '0;
    end else if ((state == ST_FETCH) && in_valid) begin
      uds_idata <= in_data;
    end
  end

  assign cfg_busy        = (state != ST_IDLE);
  assign cfg_done        = (state == ST_DONE);
  assign cfg_err         = err_q;
  assign in_ready        = (state == ST_FETCH);
  assign uds_idata_valid = (state == ST_LOAD);
  assign uds_active      = (state == ST_COMPUTE);
  assign out_valid       = (state == ST_HOLD);

endmodule

// File: tb/tb_uds_seq_ctrl.sv
// Directed bench for uds_seq_ctrl with a two-cycle UDS model and a tile-index
// scoreboard; the watchdog scenario is built only when UDS_WDOG_EN is defined.
module tb_uds_seq_ctrl;
  import uds_pkg::*;

  localparam int A     = 64;
  localparam int DW    = 32;
  localparam int CNT_W = 8;

  logic              clk;
  logic              rst_n;
  logic              cfg_start;
  logic [1:0]        cfg_mode;
  logic [1:0]        cfg_scale;
  logic [CNT_W-1:0]  cfg_tiles;
  logic              cfg_busy, cfg_done, cfg_err;
  logic              in_valid, in_ready;
  logic [A*DW-1:0]   in_data;
  logic [A*DW-1:0]   uds_idata;
  logic              uds_idata_valid, uds_active;
  logic [1:0]        uds_function_mode, uds_scale_factor;
  logic              uds_odata_valid;
  logic              out_valid, out_ready;
  logic [CNT_W-1:0]  out_tile_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_idx_q[$];
  logic [A*DW-1:0] exp_data;
  logic [2:0] act_p;
  logic       model_en;

  uds_seq_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_start         (cfg_start),
    .cfg_mode          (cfg_mode),
    .cfg_scale         (cfg_scale),
    .cfg_tiles         (cfg_tiles),
    .cfg_busy          (cfg_busy),
    .cfg_done          (cfg_done),
    .cfg_err           (cfg_err),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .uds_idata         (uds_idata),
    .uds_idata_valid   (uds_idata_valid),
    .uds_active        (uds_active),
    .uds_function_mode (uds_function_mode),
    .uds_scale_factor  (uds_scale_factor),
    .uds_odata_valid   (uds_odata_valid),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_tile_idx      (out_tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UDS model: result valid two cycles after the compute strobe; upsample adds a second pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) act_p <= '0;
    else        act_p <= {act_p[1:0], uds_active};
  end
  assign uds_odata_valid = model_en && (act_p[1] || (uds_function_mode[1] && act_p[2]));

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_data();
    for (int w = 0; w < A; w++) in_data[w*DW +: DW] = $urandom();
  endtask

  task automatic run_job(input logic [1:0] mode, input logic [1:0] scale,
                         input logic [CNT_W-1:0] tiles, input int stall, input logic exp_err);
    int   start_cyc, xfer_edge, acc_cyc, stall_left, iter;
    logic pend, in_hold, done_seen, saw_in_ready;
    logic [CNT_W-1:0] held_idx;
    if (!exp_err) for (int i = 0; i < int'(tiles); i++) exp_idx_q.push_back(i);
    cfg_mode  = mode;
    cfg_scale = scale;
    cfg_tiles = tiles;
    cfg_start = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    cfg_start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", cfg_busy, 1'b1);
    check("mode_latched", uds_function_mode, mode);
    check("scale_latched", uds_scale_factor, scale);
    check("err_after_start", cfg_err, exp_err);
    pend = 0; in_hold = 0; done_seen = 0; saw_in_ready = 0;
    acc_cyc = -1; xfer_edge = 0; stall_left = stall; held_idx = '0;
    for (iter = 0; iter < 2000; iter++) begin
      if (pend) begin
        check("load_strobe", {uds_idata_valid, uds_active}, 2'b10);
        check("idata_capture", uds_idata === exp_data, 1'b1);
        pend = 0;
      end
      if (cfg_done) begin
        check("done_err", cfg_err, exp_err);
        check("queue_empty", exp_idx_q.size(), 0);
        if (acc_cyc >= 0) check("done_after_accept", cyc - acc_cyc, 1);
        else              check("done_after_start", cyc - start_cyc, 0);
        done_seen = 1;
        break;
      end
      cfg_start = (iter == 3);
      cfg_mode  = (iter == 3) ? ~mode : mode;
      drive_data();
      if (in_ready) saw_in_ready = 1;
      if (in_ready && in_valid) begin
        exp_data  = in_data;
        xfer_edge = cyc + 1;
        pend      = 1;
      end
      if (in_hold && !out_valid) begin
        check("out_valid_dropped", out_valid, 1'b1);
        in_hold = 0;
      end
      if (out_valid) begin
        if (!in_hold) begin
          check("tile_latency", cyc - xfer_edge, 4);
          held_idx = out_tile_idx;
          in_hold  = 1;
        end else begin
          check("hold_idx_stable", out_tile_idx, held_idx);
          check("hold_in_ready", in_ready, 1'b0);
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          if (exp_idx_q.size() == 0) check("extra_out_valid", 1'b1, 1'b0);
          else                       check("tile_idx", out_tile_idx, exp_idx_q.pop_front());
          acc_cyc    = cyc;
          in_hold    = 0;
          stall_left = stall;
        end
      end else begin
        out_ready = 1'b1;
      end
      step();
    end
    cfg_start = 1'b0;
    cfg_mode  = mode;
    if (!done_seen) check("job_timeout", 1'b0, 1'b1);
    if (tiles == '0 || exp_err) check("no_fetch", saw_in_ready, 1'b0);
    step();
    check("idle_busy", cfg_busy, 1'b0);
    check("done_one_cycle", cfg_done, 1'b0);
    check("err_sticky", cfg_err, exp_err);
    check("mode_kept", uds_function_mode, mode);
  endtask

  initial begin
    int reached;
    rst_n     = 1'b0;
    model_en  = 1'b1;
    cfg_start = 1'b0;
    cfg_mode  = '0;
    cfg_scale = '0;
    cfg_tiles = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_ctrl", {cfg_busy, cfg_done, cfg_err, in_ready, uds_idata_valid, uds_active, out_valid}, 7'b0);
    check("rst_cfg", {uds_function_mode, uds_scale_factor, out_tile_idx}, '0);
    check("rst_idata", uds_idata === '0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_job(FUNC_DOWN_MAX, SCALE_2X2, 8'd3, 0, 1'b0);
    run_job(FUNC_UPSAMPLE, 2'b01, 8'd1, 0, 1'b0);
    run_job(FUNC_DOWN_AVG, SCALE_2X2, 8'd2, 5, 1'b0);
    run_job(FUNC_DOWN_MAX, SCALE_2X2, 8'd0, 0, 1'b0);
    run_job(FUNC_DOWN_MAX, 2'b01, 8'd2, 0, 1'b1);
    run_job(FUNC_UPSAMPLE, 2'b11, 8'd2, 1, 1'b0);

    // Reset asserted during COMPUTE of tile 1.
    cfg_mode  = FUNC_DOWN_MAX;
    cfg_scale = SCALE_2X2;
    cfg_tiles = 8'd3;
    cfg_start = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    cfg_start = 1'b0;
    reached   = 0;
    for (int i = 0; i < 200; i++) begin
      if (uds_active && out_tile_idx == 8'd1) begin
        reached = 1;
        break;
      end
      drive_data();
      step();
    end
    check("reach_compute_t1", reached, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {cfg_busy, cfg_done, cfg_err, in_ready, uds_idata_valid, uds_active, out_valid}, 7'b0);
    check("midrst_cfg", {uds_function_mode, uds_scale_factor, out_tile_idx}, '0);
    check("midrst_idata", uds_idata === '0, 1'b1);
    exp_idx_q.delete();
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_job(FUNC_DOWN_MAX, SCALE_2X2, 8'd2, 0, 1'b0);

`ifdef UDS_WDOG_EN
    begin
      int comp_cyc, got_done;
      model_en  = 1'b0;
      cfg_mode  = FUNC_DOWN_MAX;
      cfg_scale = SCALE_2X2;
      cfg_tiles = 8'd2;
      cfg_start = 1'b1;
      in_valid  = 1'b1;
      step();
      cfg_start = 1'b0;
      comp_cyc  = -100;
      got_done  = 0;
      for (int i = 0; i < 200; i++) begin
        if (uds_active) comp_cyc = cyc;
        if (cfg_done) begin
          got_done = 1;
          break;
        end
        step();
      end
      check("wdog_done", got_done, 1);
      check("wdog_delay", cyc - comp_cyc - 1, 16);
      check("wdog_err", cfg_err, 1'b1);
      model_en = 1'b1;
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
